// File: rtl/zx_screen_render.sv
// ZX Spectrum screen renderer for the RGB565 LCD path.
// Consumes pixel coordinates and DE from the LCD timing generator, fetches
// bitmap/attribute bytes from the screen RAM one cell ahead, and produces
// border/paper/ink colour three clocks after the coordinates arrive.
// Optional feature macro: ZX_PALETTE_EN adds a writable 16-entry RGB565
// palette (pal_we/pal_idx/pal_data) in place of the fixed colour mapping.
// SCALE_LOG2 must be 0, 1 or 2.

module zx_screen_render #(
    parameter int H_W        = 10,
    parameter int V_W        = 10,
    parameter int X_START    = 24,
    parameter int Y_START    = 0,
    parameter int SCALE_LOG2 = 0,
    parameter int FLASH_LOG2 = 4
) (
    input  logic           PixelClk,
    input  logic           nRST,
    input  logic           de_in,
    input  logic [H_W-1:0] x_in,
    input  logic [V_W-1:0] y_in,
    input  logic           frame_tick,
    input  logic [2:0]     border,
    output logic [12:0]    ram_addr,
    output logic           ram_re,
    input  logic [7:0]     pix_data,
    input  logic [7:0]     attr_data,
    output logic           de_out,
    output logic [15:0]    rgb
`ifdef ZX_PALETTE_EN
    ,
    input  logic           pal_we,
    input  logic [3:0]     pal_idx,
    input  logic [15:0]    pal_data
`endif
);

    localparam int SCALE  = 1 << SCALE_LOG2;
    localparam int WIN_W  = 256 << SCALE_LOG2;
    localparam int WIN_H  = 192 << SCALE_LOG2;
    localparam int CELL_W = 8 << SCALE_LOG2;

    // Fixed ZX mapping from colour index {bright,G,R,B} to RGB565.
    function automatic logic [15:0] fixed_rgb(input logic [3:0] idx);
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
        r5 = idx[1] ? (idx[3] ? 5'h1F : 5'h10) : 5'h00;
        g6 = idx[2] ? (idx[3] ? 6'h3F : 6'h20) : 6'h00;
        b5 = idx[0] ? (idx[3] ? 5'h1F : 5'h10) : 5'h00;
        return {r5, g6, b5};
    endfunction

    // Window offsets; anything left/above the window wraps to a large value
    // and therefore falls outside the unsigned range check.
    logic [H_W-1:0] off_x;
    logic [H_W-1:0] off_xa;
    logic [V_W-1:0] off_y;
    logic           in_x;
    logic           in_xa;
    logic           in_y;
    logic           cell_start;
    logic           fetch0;
    logic [7:0]     sy0;
    logic [4:0]     cell_a;

    // off_xa looks two pixels ahead so the byte is in the shifter before
    // the first pixel of its cell reaches the colour stage.
    assign off_x      = x_in - H_W'(X_START);
    assign off_xa     = x_in + H_W'(2) - H_W'(X_START);
    assign off_y      = y_in - V_W'(Y_START);
    assign in_x       = (32'(off_x) < 32'(WIN_W));
    assign in_xa      = (32'(off_xa) < 32'(WIN_W));
    assign in_y       = (32'(off_y) < 32'(WIN_H));
    assign cell_start = ((32'(off_xa) & 32'(CELL_W - 1)) == 32'd0);
    assign fetch0     = de_in && in_y && in_xa && cell_start;
    assign sy0        = 8'(off_y >> SCALE_LOG2);
    assign cell_a     = 5'(off_xa >> (SCALE_LOG2 + 3));

    logic           load_pend;
    logic [7:0]     shifter;
    logic [7:0]     attr_reg;
    logic [1:0]     scale_cnt;
    logic [FLASH_LOG2:0] flash_cnt;
    logic           de1;
    logic           win1;
    logic           phase1;
    logic [2:0]     border1;
    logic           ink_on;
    logic [3:0]     idx1;
    logic           de2;
    logic [3:0]     idx2;
    logic [15:0]    colour2;

    // Issue one RAM read per cell, with the ZX interleaved bitmap address.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            ram_re    <= 1'b0;
            ram_addr  <= 13'd0;
            load_pend <= 1'b0;
        end else begin
            ram_re    <= fetch0;
            load_pend <= ram_re;
            if (fetch0) begin
                ram_addr <= {sy0[7:6], sy0[2:0], sy0[5:3], cell_a};
            end
        end
    end

    // Load the returned byte pair, otherwise shift once per replicated pixel.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            shifter   <= 8'd0;
            attr_reg  <= 8'd0;
            scale_cnt <= 2'd0;
        end else if (load_pend) begin
            shifter   <= pix_data;
            attr_reg  <= attr_data;
            scale_cnt <= 2'd0;
        end else if (scale_cnt == 2'(SCALE - 1)) begin
            shifter   <= {shifter[6:0], 1'b0};
            scale_cnt <= 2'd0;
        end else begin
            scale_cnt <= scale_cnt + 2'd1;
        end
    end

    // Frame counter whose MSB is the FLASH phase.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            flash_cnt <= '0;
        end else if (frame_tick) begin
            flash_cnt <= flash_cnt + (FLASH_LOG2 + 1)'(1);
        end
    end

    // First pipeline stage: capture per-pixel control and the pre-tick phase.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de1     <= 1'b0;
            win1    <= 1'b0;
            phase1  <= 1'b0;
            border1 <= 3'd0;
        end else begin
            de1     <= de_in;
            win1    <= in_x && in_y;
            phase1  <= flash_cnt[FLASH_LOG2];
            border1 <= border;
        end
    end

    // Choose ink, paper or border as a 4-bit colour index.
    always_comb begin
        ink_on = shifter[7] ^ (attr_reg[7] & phase1);
        idx1   = {1'b0, border1};
        if (win1) begin
            idx1 = {attr_reg[6], ink_on ? attr_reg[2:0] : attr_reg[5:3]};
        end
    end

    // Second pipeline stage: hold the colour index for the lookup.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de2  <= 1'b0;
            idx2 <= 4'd0;
        end else begin
            de2  <= de1;
            idx2 <= idx1;
        end
    end

`ifdef ZX_PALETTE_EN
    logic [15:0] pal [16];

    // Writable palette, reset to the fixed mapping; a write becomes visible
    // to lookups from the following clock.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 16; i++) begin
                pal[i] <= fixed_rgb(4'(i));
            end
        end else if (pal_we) begin
            pal[pal_idx] <= pal_data;
        end
    end

    assign colour2 = pal[idx2];
`else
    assign colour2 = fixed_rgb(idx2);
`endif

    // Output stage: blank outside DE, otherwise the looked-up colour.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de_out <= 1'b0;
            rgb    <= 16'h0000;
        end else begin
            de_out <= de2;
            rgb    <= de2 ? colour2 : 16'h0000;
        end
    end

endmodule

// File: tb/tb_zx_screen_render.sv
// Self-checking bench for zx_screen_render: a 1x and a 2x instance share the
// timing inputs; each has its own screen-RAM read port. A behavioural model
// computes every expected pixel from the screen-layout rules.

module tb_zx_screen_render;

    localparam int X_START    = 24;
    localparam int Y_START    = 0;
    localparam int FLASH_LOG2 = 4;
    localparam int LINE_LEN   = 600;
    localparam int DE_LEN     = 560;

    typedef struct {
        bit         de;
        logic [3:0] idx;
        int         x;
    } exp_t;

    logic        PixelClk = 1'b0;
    logic        nRST = 1'b1;
    logic        de_in = 1'b0;
    logic [9:0]  x_in = '0;
    logic [9:0]  y_in = '0;
    logic        frame_tick = 1'b0;
    logic [2:0]  border = '0;
    logic [12:0] ram_addr1, ram_addr2;
    logic        ram_re1, ram_re2;
    logic [7:0]  pix_data1 = '0, attr_data1 = '0;
    logic [7:0]  pix_data2 = '0, attr_data2 = '0;
    logic        de_out1, de_out2;
    logic [15:0] rgb1, rgb2;
`ifdef ZX_PALETTE_EN
    logic        pal_we = 1'b0;
    logic [3:0]  pal_idx = '0;
    logic [15:0] pal_data = '0;
`endif

    logic [7:0]  pix_mem  [0:8191];
    logic [7:0]  attr_mem [0:8191];
    logic [15:0] pal_m [16];
    logic [15:0] pal_lag [16];
    logic [15:0] cap1 [0:1023];
    logic [15:0] cap2 [0:1023];
    logic [12:0] re_addr1 [$];
    logic [12:0] re_addr2 [$];
    exp_t        q1 [$];
    exp_t        q2 [$];
    int          flash_cnt_m;
    int          checks = 0;
    int          passes = 0;
    logic [15:0] exp_a5 [8] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000,
                                16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};

    zx_screen_render #(.X_START(X_START), .Y_START(Y_START), .SCALE_LOG2(0),
                       .FLASH_LOG2(FLASH_LOG2)) dut1 (
        .PixelClk(PixelClk), .nRST(nRST), .de_in(de_in), .x_in(x_in),
        .y_in(y_in), .frame_tick(frame_tick), .border(border),
        .ram_addr(ram_addr1), .ram_re(ram_re1), .pix_data(pix_data1),
        .attr_data(attr_data1), .de_out(de_out1), .rgb(rgb1)
`ifdef ZX_PALETTE_EN
        , .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data)
`endif
    );

    zx_screen_render #(.X_START(X_START), .Y_START(Y_START), .SCALE_LOG2(1),
                       .FLASH_LOG2(FLASH_LOG2)) dut2 (
        .PixelClk(PixelClk), .nRST(nRST), .de_in(de_in), .x_in(x_in),
        .y_in(y_in), .frame_tick(frame_tick), .border(border),
        .ram_addr(ram_addr2), .ram_re(ram_re2), .pix_data(pix_data2),
        .attr_data(attr_data2), .de_out(de_out2), .rgb(rgb2)
`ifdef ZX_PALETTE_EN
        , .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data)
`endif
    );

    always #5 PixelClk = ~PixelClk;

    // Synchronous screen RAM: data appears the cycle after the read strobe.
    always @(posedge PixelClk) begin
        if (ram_re1 === 1'b1) begin
            pix_data1  <= pix_mem[ram_addr1];
            attr_data1 <= attr_mem[ram_addr1];
        end
        if (ram_re2 === 1'b1) begin
            pix_data2  <= pix_mem[ram_addr2];
            attr_data2 <= attr_mem[ram_addr2];
        end
    end

    function automatic logic [15:0] fixed_map(input int idx);
        int b, g, r, bl, r5, g6, b5;
        b  = (idx >> 3) & 1;
        g  = (idx >> 2) & 1;
        r  = (idx >> 1) & 1;
        bl = idx & 1;
        r5 = r  ? (b ? 31 : 16) : 0;
        g6 = g  ? (b ? 63 : 32) : 0;
        b5 = bl ? (b ? 31 : 16) : 0;
        return 16'(r5 * 2048 + g6 * 32 + b5);
    endfunction

    function automatic int model_addr(input int sx, input int sy);
        return (sy / 64) * 2048 + (sy % 8) * 256 + ((sy / 8) % 8) * 32 + sx / 8;
    endfunction

    function automatic exp_t model_pixel(input int s, input bit de, input int x,
                                         input int y, input logic [2:0] brd,
                                         input bit phase);
        exp_t e;
        int offx, offy, sx, sy, addr;
        logic [7:0] p, a;
        bit ink;
        e.de  = de;
        e.x   = x;
        e.idx = {1'b0, brd};
        offx  = (x - X_START) & 1023;
        offy  = (y - Y_START) & 1023;
        if (offx < (256 << s) && offy < (192 << s)) begin
            sx    = offx >> s;
            sy    = offy >> s;
            addr  = model_addr(sx, sy);
            p     = pix_mem[addr];
            a     = attr_mem[addr];
            ink   = p[7 - (sx % 8)] ^ (a[7] & phase);
            e.idx = {a[6], ink ? a[2:0] : a[5:3]};
        end
        return e;
    endfunction

    task automatic reset_model();
        exp_t z;
        z.de = 1'b0;
        z.idx = 4'd0;
        z.x = -1;
        flash_cnt_m = 0;
        for (int i = 0; i < 16; i++) pal_m[i] = fixed_map(i);
        pal_lag = pal_m;
        q1.delete();
        q2.delete();
        repeat (3) begin
            q1.push_back(z);
            q2.push_back(z);
        end
    endtask

    // One clock: check outputs against the pixel driven three cycles ago,
    // queue the expectation for the current inputs, then advance.
    task automatic step();
        exp_t e;
        logic [15:0] want;
        bit phase;
        if (q1.size() == 3) begin
            e = q1.pop_front();
            want = e.de ? pal_lag[e.idx] : 16'h0000;
            checks++;
            if (de_out1 !== e.de || rgb1 !== want)
                $display("[TB] FAIL pix1 x=%0d y=%0d: got de=%b rgb=%h, want de=%b rgb=%h",
                         e.x, y_in, de_out1, rgb1, e.de, want);
            else passes++;
            if (e.x >= 0) cap1[e.x] = rgb1;
        end
        if (q2.size() == 3) begin
            e = q2.pop_front();
            want = e.de ? pal_lag[e.idx] : 16'h0000;
            checks++;
            if (de_out2 !== e.de || rgb2 !== want)
                $display("[TB] FAIL pix2 x=%0d y=%0d: got de=%b rgb=%h, want de=%b rgb=%h",
                         e.x, y_in, de_out2, rgb2, e.de, want);
            else passes++;
            if (e.x >= 0) cap2[e.x] = rgb2;
        end
        if (ram_re1 === 1'b1) re_addr1.push_back(ram_addr1);
        if (ram_re2 === 1'b1) re_addr2.push_back(ram_addr2);
        phase = ((flash_cnt_m >> FLASH_LOG2) & 1) != 0;
        q1.push_back(model_pixel(0, de_in, int'(x_in), int'(y_in), border, phase));
        q2.push_back(model_pixel(1, de_in, int'(x_in), int'(y_in), border, phase));
        @(posedge PixelClk);
        #1;
        if (frame_tick) flash_cnt_m = (flash_cnt_m + 1) % (2 << FLASH_LOG2);
        pal_lag = pal_m;
`ifdef ZX_PALETTE_EN
        if (pal_we) pal_m[pal_idx] = pal_data;
`endif
    endtask

    task automatic apply_reset();
        nRST = 1'b1;
        de_in = 1'b0;
        frame_tick = 1'b0;
        #1;
        nRST = 1'b0;
        #1;
        checks++;
        if (rgb1 !== 16'h0 || de_out1 !== 1'b0 || ram_re1 !== 1'b0 || ram_addr1 !== 13'h0 ||
            rgb2 !== 16'h0 || de_out2 !== 1'b0 || ram_re2 !== 1'b0 || ram_addr2 !== 13'h0)
            $display("[TB] FAIL reset_state: got rgb=%h/%h de=%b/%b re=%b/%b addr=%h/%h, want all 0",
                     rgb1, rgb2, de_out1, de_out2, ram_re1, ram_re2, ram_addr1, ram_addr2);
        else passes++;
        @(posedge PixelClk); #1;
        @(posedge PixelClk); #1;
        nRST = 1'b1;
        reset_model();
    endtask

    task automatic mid_reset();
        nRST = 1'b0;
        #1;
        checks++;
        if (rgb1 !== 16'h0 || de_out1 !== 1'b0 || rgb2 !== 16'h0 || de_out2 !== 1'b0)
            $display("[TB] FAIL midline_reset: got rgb=%h/%h de=%b/%b, want 0",
                     rgb1, rgb2, de_out1, de_out2);
        else passes++;
        @(posedge PixelClk); #1;
        @(posedge PixelClk); #1;
        nRST = 1'b1;
        reset_model();
    endtask

    // Sweep one full line; brd<0 means random border every cycle.
    task automatic run_line(input int y, input bit rand_ticks, input int brd,
                            input int reset_x, input int pal_x);
        int exp1, exp2, bad1, bad2;
        re_addr1.delete();
        re_addr2.delete();
        for (int x = 0; x < LINE_LEN; x++) begin
            x_in       = 10'(x);
            y_in       = 10'(y);
            de_in      = (x < DE_LEN);
            border     = (brd < 0) ? 3'($urandom) : 3'(brd);
            frame_tick = rand_ticks && ($urandom_range(0, 63) == 0);
`ifdef ZX_PALETTE_EN
            pal_we   = (x == pal_x);
            pal_idx  = 4'h2;
            pal_data = 16'h07E0;
`else
            if (pal_x == x) $display("[TB] palette write skipped at x=%0d", x);
`endif
            if (x == reset_x) mid_reset();
            step();
        end
        frame_tick = 1'b0;
`ifdef ZX_PALETTE_EN
        pal_we = 1'b0;
`endif
        exp1 = (y - Y_START >= 0 && y - Y_START < 192) ? 32 : 0;
        exp2 = (y - Y_START >= 0 && y - Y_START < 384) ? 32 : 0;
        checks++;
        if (re_addr1.size() != exp1 || re_addr2.size() != exp2)
            $display("[TB] FAIL ram_re_count y=%0d: got %0d/%0d, want %0d/%0d",
                     y, re_addr1.size(), re_addr2.size(), exp1, exp2);
        else passes++;
        bad1 = 0;
        bad2 = 0;
        for (int k = 0; k < re_addr1.size() && k < 32; k++)
            if (re_addr1[k] !== 13'(model_addr(k * 8, y - Y_START))) bad1++;
        for (int k = 0; k < re_addr2.size() && k < 32; k++)
            if (re_addr2[k] !== 13'(model_addr(k * 8, (y - Y_START) / 2))) bad2++;
        checks++;
        if (bad1 != 0 || bad2 != 0)
            $display("[TB] FAIL ram_addr y=%0d: got %0d/%0d wrong addresses, want 0", y, bad1, bad2);
        else passes++;
    endtask

    task automatic tick_frames(input int n);
        de_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        apply_reset();
        run_line(0, 1'b0, 2, -1, -1);
        for (int x = 0; x < 8; x++) begin
            checks++;
            if (cap1[x] !== 16'h8000)
                $display("[TB] FAIL border_x%0d: got %h, want 8000", x, cap1[x]);
            else passes++;
        end
    endtask

    task automatic test_bitmap();
        $display("[TB] test_bitmap");
        pix_mem[0]  = 8'hA5;
        attr_mem[0] = 8'h47;
        pix_mem[31]  = 8'h01;
        attr_mem[31] = 8'h47;
        run_line(0, 1'b0, 1, -1, -1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap1[X_START + i] !== exp_a5[i])
                $display("[TB] FAIL bitmap_1x_%0d: got %h, want %h", i, cap1[X_START + i], exp_a5[i]);
            else passes++;
        end
        checks++;
        if (cap1[X_START + 255] !== 16'hFFFF || cap1[X_START + 256] !== 16'h0010)
            $display("[TB] FAIL window_end_1x: got %h %h, want ffff 0010",
                     cap1[X_START + 255], cap1[X_START + 256]);
        else passes++;
    endtask

    task automatic test_scale();
        $display("[TB] test_scale");
        run_line(1, 1'b0, 1, -1, -1);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (cap2[X_START + i] !== exp_a5[i / 2])
                $display("[TB] FAIL bitmap_2x_%0d: got %h, want %h", i, cap2[X_START + i], exp_a5[i / 2]);
            else passes++;
        end
        checks++;
        if (cap2[X_START + 511] !== 16'hFFFF || cap2[X_START + 512] !== 16'h0010)
            $display("[TB] FAIL window_end_2x: got %h %h, want ffff 0010",
                     cap2[X_START + 511], cap2[X_START + 512]);
        else passes++;
    endtask

    task automatic test_flash();
        $display("[TB] test_flash");
        apply_reset();
        pix_mem[0]  = 8'hFF;
        attr_mem[0] = 8'h87;
        run_line(0, 1'b0, 0, -1, -1);
        checks++;
        if (cap1[X_START] !== 16'h8410)
            $display("[TB] FAIL flash_0: got %h, want 8410", cap1[X_START]);
        else passes++;
        tick_frames(16);
        run_line(0, 1'b0, 0, -1, -1);
        checks++;
        if (cap1[X_START] !== 16'h0000)
            $display("[TB] FAIL flash_16: got %h, want 0000", cap1[X_START]);
        else passes++;
        tick_frames(16);
        run_line(0, 1'b0, 0, -1, -1);
        checks++;
        if (cap1[X_START] !== 16'h8410)
            $display("[TB] FAIL flash_32: got %h, want 8410", cap1[X_START]);
        else passes++;
    endtask

    task automatic test_boundaries();
        $display("[TB] test_boundaries");
        for (int i = 0; i < 6144; i++) begin
            pix_mem[i]  = 8'($urandom);
            attr_mem[i] = 8'($urandom);
        end
        run_line(191, 1'b0, -1, -1, -1);
        run_line(192, 1'b0, -1, -1, -1);
        run_line(383, 1'b0, -1, -1, -1);
        run_line(384, 1'b0, -1, -1, -1);
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        for (int n = 0; n < 6; n++) begin
            run_line($urandom_range(0, 400), 1'b1, -1, -1, -1);
        end
    endtask

    task automatic test_midline_reset();
        $display("[TB] test_midline_reset");
        run_line(5, 1'b0, -1, 10, -1);
    endtask

    task automatic test_palette();
`ifdef ZX_PALETTE_EN
        $display("[TB] test_palette");
        apply_reset();
        for (int k = 0; k < 32; k++) begin
            pix_mem[k]  = 8'h00;
            attr_mem[k] = 8'h10;
        end
        run_line(0, 1'b0, 0, -1, 100);
        checks++;
        if (cap1[98] !== 16'h8000 || cap1[99] !== 16'h07E0 || cap1[200] !== 16'h07E0)
            $display("[TB] FAIL palette_write: got %h %h %h, want 8000 07e0 07e0",
                     cap1[98], cap1[99], cap1[200]);
        else passes++;
`else
        $display("[TB] test_palette not built");
`endif
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            pix_mem[i]  = 8'h00;
            attr_mem[i] = 8'h00;
        end
        for (int i = 0; i < 1024; i++) begin
            cap1[i] = 16'h0;
            cap2[i] = 16'h0;
        end
        test_reset();
        test_bitmap();
        test_scale();
        test_flash();
        test_boundaries();
        test_random();
        test_midline_reset();
        test_palette();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
